// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the oversampled UART receiver family.
//               Holds the receive FSM encoding, the parity-mode constants, the
//               legal parameter ranges and a 3-input majority helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    // Receive FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Legal parameter ranges
    localparam int BAUD_DIV_MIN  = 16;
    localparam int BAUD_DIV_MAX  = 2047;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    // 2-of-3 vote used for the mid-bit decision
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_param_if.sv
//==============================================================================
// Module      : uart_rx_param_if
// Description : Signal bundle between the UART receiver and its consumer.
//               master : the receiver (samples rxsdi, drives the results)
//               slave  : the line driver / word consumer
//               Signals: rxsdi, rxpd, rxen, rx_start, parity_err, frame_err,
//               busy; with UART_RX_FIFO_EN defined also rd, empty, overrun.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxsdi;
    logic [DATA_BITS-1:0] rxpd;
    logic                 rxen;
    logic                 rx_start;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_FIFO_EN
    logic                 rd;
    logic                 empty;
    logic                 overrun;

    modport master (
        input  rxsdi, rd,
        output rxpd, rxen, rx_start, parity_err, frame_err, busy, empty, overrun
    );
    modport slave (
        output rxsdi, rd,
        input  rxpd, rxen, rx_start, parity_err, frame_err, busy, empty, overrun
    );
`else
    modport master (
        input  rxsdi,
        output rxpd, rxen, rx_start, parity_err, frame_err, busy
    );
    modport slave (
        output rxsdi,
        input  rxpd, rxen, rx_start, parity_err, frame_err, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
//==============================================================================
// Module      : uart_rx_sync
// Description : 2-FF synchroniser for an asynchronous serial line, followed by
//               a previous-sample register and falling-edge detect.
//               All stages reset to 1 (idle line level) so a line that is low
//               out of reset produces exactly one edge after the chain fills.
// Ports       : clk, rst   - system clock / synchronous active-high reset
//               rxsdi      - asynchronous serial input
//               sync       - synchronised line level
//               fall       - high while sync=0 and the previous sample was 1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic rxsdi,
    output logic      sync,
    output logic      fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rxsdi;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
//==============================================================================
// Module      : uart_rx_param
// Description : Oversampled UART receiver running directly on the system
//               clock. Each bit is decided by a 2-of-3 vote of the samples at
//               cnt = MID-1, MID, MID+1 (MID = BAUD_DIV/2). Words are
//               delivered LSB first with parity/framing error flags.
//               Optional macro UART_RX_FIFO_EN adds a 4-entry result FIFO
//               (rd/empty/overrun); rxen then means "FIFO not empty".
// Ports       : clk, rst - system clock / synchronous active-high reset
//               rx       - uart_rx_param_if.master bundle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = 1042,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_rx_param_if.master rx
);

    localparam int                CNT_W   = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] MID     = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] MID_P1  = CNT_W'(BAUD_DIV / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (BAUD_DIV < BAUD_DIV_MIN || BAUD_DIV > BAUD_DIV_MAX ||
            DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
            PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_rx_param: illegal parameter combination");
        end
    endgenerate

    logic w_sync;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxsdi (rx.rxsdi),
        .sync  (w_sync),
        .fall  (w_fall)
    );

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_smp_a;
    logic                 r_smp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;
    logic                 r_start_pulse;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_tick;
    logic w_vote;
    logic w_par_xor;

    // The third vote sample is the live synchronised level at cnt = MID+1.
    assign w_tick    = (r_cnt == MID_P1);
    assign w_vote    = majority3(r_smp_a, r_smp_b, w_sync);
    assign w_par_xor = (^r_shift) ^ w_vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_smp_a       <= 1'b1;
            r_smp_b       <= 1'b1;
            r_shift       <= '0;
            r_perr_acc    <= 1'b0;
            r_ferr_acc    <= 1'b0;
            r_start_pulse <= 1'b0;
            r_done        <= 1'b0;
            r_data        <= '0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            r_done        <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;

            if (r_cnt == MID_M1) r_smp_a <= w_sync;
            if (r_cnt == MID)    r_smp_b <= w_sync;

            // Free-running within a frame: after the start-bit vote at MID+1
            // the wrap keeps every later vote exactly BAUD_DIV cycles apart,
            // i.e. at mid-bit.
            if (r_state == ST_IDLE || r_cnt == CNT_MAX) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state       <= ST_START;
                        r_start_pulse <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (w_vote) begin
                            r_state <= ST_IDLE;       // glitch, not a start bit
                        end else begin
                            r_state    <= ST_DATA;
                            r_bit_idx  <= '0;
                            r_perr_acc <= 1'b0;
                            r_ferr_acc <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_perr_acc <= (PARITY_MODE == PARITY_ODD) ? ~w_par_xor : w_par_xor;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_vote) r_ferr_acc <= 1'b1;
                        if (r_bit_idx == LAST_STOP) begin
                            // Back to IDLE at mid-bit so a start edge right at
                            // the end of the stop bit is not missed.
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_data  <= r_shift;
                            r_perr  <= r_perr_acc;
                            r_ferr  <= r_ferr_acc | ~w_vote;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx.rx_start = r_start_pulse;
    assign rx.busy     = (r_state != ST_IDLE);

`ifdef UART_RX_FIFO_EN
    localparam int FW = DATA_BITS + 2;

    logic [FW-1:0] r_mem [4];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic [2:0]    r_count;
    logic          r_not_empty;
    logic          r_overrun;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_count_nxt;
    logic [FW-1:0] w_head;

    assign w_full = (r_count == 3'd4);
    assign w_pop  = rx.rd & r_not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = r_done & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 3'd1;
        else if (!w_push && w_pop) w_count_nxt = r_count - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_not_empty <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_perr, r_ferr, r_data};
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            if (r_done && !w_push) r_overrun <= 1'b1;
            r_count     <= w_count_nxt;
            r_not_empty <= (w_count_nxt != 3'd0);
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rx.rxen       = r_not_empty;
    assign rx.rxpd       = r_not_empty ? w_head[DATA_BITS-1:0] : '0;
    assign rx.parity_err = r_not_empty & w_head[FW-1];
    assign rx.frame_err  = r_not_empty & w_head[FW-2];
    assign rx.empty      = ~r_not_empty;
    assign rx.overrun    = r_overrun;
`else
    assign rx.rxen       = r_done;
    assign rx.rxpd       = r_data;
    assign rx.parity_err = r_perr;
    assign rx.frame_err  = r_ferr;
`endif

endmodule

`default_nettype wire
